// File: rtl/alu_arb_pkg.sv
// Shared opcodes, flag indices, FSM state and opcode helpers for alu_arbiter.
package alu_arb_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b0101;
    localparam logic [3:0] OP_MOV = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SLR = 4'b1001;
    localparam logic [3:0] OP_SRL = 4'b1010;
    localparam logic [3:0] OP_SRA = 4'b1011;

    localparam int unsigned FLAG_S = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic {StIdle, StHold} arb_state_e;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP, OP_MOV,
            OP_SLL, OP_SLR, OP_SRL, OP_SRA: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    // Logic ops and MOV leave the architectural flags alone.
    function automatic logic op_writes_flags(input logic [3:0] op);
        if (!op_legal(op)) return 1'b0;
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_MOV: return 1'b0;
            default:                       return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational 16-bit ALU/shifter producing result, SZCV flags and an illegal-op error.
module alu_shifter
    import alu_arb_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic [3:0]  i_shift,
    output logic [15:0] o_res,
    output logic [3:0]  o_szcv,
    output logic        o_err
);

    logic [16:0] w_wide;
    logic [31:0] w_rot;
    logic [15:0] w_res;
    logic        w_c;
    logic        w_v;

    always_comb begin
        w_wide = '0;
        w_rot  = '0;
        w_res  = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        o_err  = !op_legal(i_op);
        case (i_op)
            OP_ADD: begin
                w_wide = {1'b0, i_a} + {1'b0, i_b};
                w_res  = w_wide[15:0];
                w_c    = w_wide[16];
                w_v    = (i_a[15] == i_b[15]) && (w_res[15] != i_a[15]);
            end
            // SUB/CMP compute b-a; C is the borrow.
            OP_SUB, OP_CMP: begin
                w_wide = {1'b0, i_b} - {1'b0, i_a};
                w_res  = w_wide[15:0];
                w_c    = w_wide[16];
                w_v    = (i_a[15] != i_b[15]) && (w_res[15] != i_b[15]);
            end
            OP_AND: w_res = i_a & i_b;
            OP_OR:  w_res = i_a | i_b;
            OP_XOR: w_res = i_a ^ i_b;
            OP_MOV: w_res = i_a;
            OP_SLL: begin
                w_wide = {1'b0, i_a} << i_shift;
                w_res  = w_wide[15:0];
                w_c    = w_wide[16];
            end
            OP_SLR: begin
                w_rot = {i_a, i_a} << i_shift;
                w_res = w_rot[31:16];
                w_c   = (i_shift != 4'd0) && w_res[0];
            end
            OP_SRL: begin
                w_wide = {i_a, 1'b0} >> i_shift;
                w_res  = w_wide[16:1];
                w_c    = w_wide[0];
            end
            OP_SRA: begin
                w_wide = $signed({i_a, 1'b0}) >>> i_shift;
                w_res  = w_wide[16:1];
                w_c    = w_wide[0];
            end
            default: ;
        endcase

        o_res  = '0;
        o_szcv = '0;
        if (!o_err) begin
            o_res          = w_res;
            o_szcv[FLAG_S] = w_res[15];
            o_szcv[FLAG_Z] = (w_res == 16'h0000);
            o_szcv[FLAG_C] = w_c;
            o_szcv[FLAG_V] = w_v;
        end
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer moves to the requester not just served.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_valid,
    input  logic [1:0] i_accept,
    output logic [1:0] o_grant
);

    logic r_ptr;

    // Each grant looks only at the other requester's valid, never its own.
    assign o_grant[0] = !i_valid[1] || !r_ptr;
    assign o_grant[1] = !i_valid[0] || r_ptr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= 1'b0;
        end else if (|i_accept) begin
            r_ptr <= i_accept[0];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu_shifter between two requesters with a registered response and SZCV flags.
// Optional wait-cycle counters are built only when ALU_ARB_PERF_EN is defined.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned TAG_W      = 2,
    parameter int unsigned FLAG_OWNER = 0,
    parameter int unsigned PERF_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][3:0]       req_op,
    input  logic [1:0][15:0]      req_a,
    input  logic [1:0][15:0]      req_b,
    input  logic [1:0][3:0]       req_shift,
    input  logic [1:0][TAG_W-1:0] req_tag,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [15:0]           rsp_res,
    output logic [3:0]            rsp_szcv,
    output logic                  rsp_err,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic [3:0]            flags_q,
    output logic [PERF_W-1:0]     perf_wait0,
    output logic [PERF_W-1:0]     perf_wait1
);

    localparam logic FLAG_OWNER_IDX = FLAG_OWNER[0];

    arb_state_e       r_state, w_state_d;
    logic             r_owner;
    logic [15:0]      r_res;
    logic [3:0]       r_szcv;
    logic             r_err;
    logic [TAG_W-1:0] r_tag;
    logic [3:0]       r_flags;

    logic [1:0]  w_grant;
    logic [1:0]  w_acc;
    logic        w_free;
    logic        w_sel;
    logic [3:0]  w_op;
    logic [15:0] w_alu_res;
    logic [3:0]  w_alu_szcv;
    logic        w_alu_err;

    assign w_free    = (r_state == StIdle) || rsp_ready[r_owner];
    assign req_ready = (w_free && !rst) ? w_grant : 2'b00;
    assign w_acc     = req_valid & req_ready;
    assign w_sel     = w_acc[1];
    assign w_op      = req_op[w_sel];

    rr_arb2 u_rr_arb2 (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (req_valid),
        .i_accept (w_acc),
        .o_grant  (w_grant)
    );

    alu_shifter u_alu_shifter (
        .i_op    (w_op),
        .i_a     (req_a[w_sel]),
        .i_b     (req_b[w_sel]),
        .i_shift (req_shift[w_sel]),
        .o_res   (w_alu_res),
        .o_szcv  (w_alu_szcv),
        .o_err   (w_alu_err)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        rsp_valid = 2'b00;
        if (r_state == StHold) rsp_valid = r_owner ? 2'b10 : 2'b01;
        if (|w_acc) begin
            w_state_d = StHold;
        end else if ((r_state == StHold) && rsp_ready[r_owner]) begin
            w_state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= 1'b0;
            r_res   <= '0;
            r_szcv  <= '0;
            r_err   <= 1'b0;
            r_tag   <= '0;
            r_flags <= '0;
        end else if (|w_acc) begin
            r_owner <= w_sel;
            r_res   <= w_alu_res;
            r_szcv  <= w_alu_szcv;
            r_err   <= w_alu_err;
            r_tag   <= req_tag[w_sel];
            if ((w_sel == FLAG_OWNER_IDX) && op_writes_flags(w_op)) r_flags <= w_alu_szcv;
        end
    end

    assign rsp_res  = r_res;
    assign rsp_szcv = r_szcv;
    assign rsp_err  = r_err;
    assign rsp_tag  = r_tag;
    assign flags_q  = r_flags;

`ifdef ALU_ARB_PERF_EN
    logic [PERF_W-1:0] r_wait0, r_wait1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait0 <= '0;
            r_wait1 <= '0;
        end else begin
            if (req_valid[0] && !req_ready[0] && (r_wait0 != '1)) r_wait0 <= r_wait0 + PERF_W'(1);
            if (req_valid[1] && !req_ready[1] && (r_wait1 != '1)) r_wait1 <= r_wait1 + PERF_W'(1);
        end
    end

    assign perf_wait0 = r_wait0;
    assign perf_wait1 = r_wait1;
`else
    assign perf_wait0 = '0;
    assign perf_wait1 = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized checks of alu_arbiter against an arithmetic reference model.
module tb_alu_arbiter;

`ifdef ALU_ARB_PERF_EN
    localparam bit PerfOn = 1'b1;
`else
    localparam bit PerfOn = 1'b0;
`endif

    typedef struct packed {
        logic        err;
        logic [3:0]  szcv;
        logic [15:0] res;
    } res_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][3:0]  req_op;
    logic [1:0][15:0] req_a;
    logic [1:0][15:0] req_b;
    logic [1:0][3:0]  req_shift;
    logic [1:0][1:0]  req_tag;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [15:0]      rsp_res;
    logic [3:0]       rsp_szcv;
    logic             rsp_err;
    logic [1:0]       rsp_tag;
    logic [3:0]       flags_q;
    logic [15:0]      perf_wait0;
    logic [15:0]      perf_wait1;

    int n_checks;
    int n_errors;

    // Reference state: pending response, preferred requester, flags, wait counts.
    bit          m_busy;
    int          m_owner;
    bit          m_pref;
    logic [15:0] m_res;
    logic [3:0]  m_szcv;
    logic        m_err;
    logic [1:0]  m_tag;
    logic [3:0]  m_flags;
    int          m_perf [2];

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_shift  (req_shift),
        .req_tag    (req_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_res    (rsp_res),
        .rsp_szcv   (rsp_szcv),
        .rsp_err    (rsp_err),
        .rsp_tag    (rsp_tag),
        .flags_q    (flags_q),
        .perf_wait0 (perf_wait0),
        .perf_wait1 (perf_wait1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t ref_alu(input logic [3:0] op, input logic [15:0] a,
                                     input logic [15:0] b, input logic [3:0] sh);
        res_t        r;
        int          ua, ub, sa, sb, t, n;
        logic [15:0] res;
        logic        c, v, legal;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        n  = int'(sh);
        t = 0; res = '0; c = 1'b0; v = 1'b0; legal = 1'b1;
        case (op)
            4'h0: begin
                t = ua + ub; res = t[15:0]; c = (t > 65535);
                v = (sa + sb > 32767) || (sa + sb < -32768);
            end
            4'h1, 4'h5: begin
                t = ub - ua; res = t[15:0]; c = (ub < ua);
                v = (sb - sa > 32767) || (sb - sa < -32768);
            end
            4'h2: res = a & b;
            4'h3: res = a | b;
            4'h4: res = a ^ b;
            4'h6: res = a;
            4'h8: begin
                t = ua << n; res = t[15:0]; c = (n != 0) && t[16];
            end
            4'h9: begin
                t = (ua << n) | (ua >> (16 - n)); res = t[15:0]; c = (n != 0) && res[0];
            end
            4'hA: begin
                t = ua >> n; res = t[15:0]; c = (n != 0) && (((ua >> (n - 1)) % 2) == 1);
            end
            4'hB: begin
                t = sa >>> n; res = t[15:0]; c = (n != 0) && (((ua >> (n - 1)) % 2) == 1);
            end
            default: legal = 1'b0;
        endcase
        r.err  = !legal;
        r.res  = legal ? res : 16'h0;
        r.szcv = legal ? {res[15], (res == 16'h0), c, v} : 4'h0;
        return r;
    endfunction

    function automatic bit ref_wf(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_pref = 0;
        m_res = '0; m_szcv = '0; m_err = 1'b0; m_tag = '0; m_flags = '0;
        m_perf[0] = 0; m_perf[1] = 0;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [3:0] sh, input logic [1:0] tag);
        req_op[i] = op; req_a[i] = a; req_b[i] = b; req_shift[i] = sh; req_tag[i] = tag;
    endtask

    // One clock: check grants mid-cycle, advance the model at the edge, check outputs after it.
    task automatic tick();
        logic [1:0] exp_acc;
        logic       free;
        int         idx;
        res_t       r;
        exp_acc = 2'b00;
        free    = 1'b0;
        #1;
        if (!rst) begin
            free = !m_busy || rsp_ready[m_owner];
            if (free) exp_acc = (req_valid == 2'b11) ? (m_pref ? 2'b10 : 2'b01) : req_valid;
        end
        chk("accept", 32'(req_valid & req_ready), 32'(exp_acc));
        if (!free) chk("ready_blocked", 32'(req_ready), 32'h0);
        idx = exp_acc[1] ? 1 : 0;
        r   = ref_alu(req_op[idx], req_a[idx], req_b[idx], req_shift[idx]);
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && !exp_acc[i] && m_perf[i] < 65535) m_perf[i]++;
            end
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (exp_acc != 2'b00) begin
            m_busy = 1; m_owner = idx; m_pref = (idx == 0);
            m_res = r.res; m_szcv = r.szcv; m_err = r.err; m_tag = req_tag[idx];
            if (idx == 0 && ref_wf(req_op[idx])) m_flags = r.szcv;
        end else if (m_busy && rsp_ready[m_owner]) begin
            m_busy = 0;
        end
        #1;
        chk("rsp_valid", 32'(rsp_valid), m_busy ? (m_owner == 1 ? 32'h2 : 32'h1) : 32'h0);
        chk("rsp_res", 32'(rsp_res), 32'(m_res));
        chk("rsp_szcv", 32'(rsp_szcv), 32'(m_szcv));
        chk("rsp_err", 32'(rsp_err), 32'(m_err));
        chk("rsp_tag", 32'(rsp_tag), 32'(m_tag));
        chk("flags_q", 32'(flags_q), 32'(m_flags));
        chk("perf_wait0", 32'(perf_wait0), PerfOn ? 32'(m_perf[0]) : 32'h0);
        chk("perf_wait1", 32'(perf_wait1), PerfOn ? 32'(m_perf[1]) : 32'h0);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        set_req(0, 4'h0, 16'h0, 16'h0, 4'h0, 2'h0);
        set_req(1, 4'h0, 16'h0, 16'h0, 4'h0, 2'h0);
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // ADD overflow into the sign bit, owner requester updates flags.
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        set_req(0, 4'h0, 16'h7FFF, 16'h0001, 4'h0, 2'h1);
        tick();
        chk("add_res", 32'(rsp_res), 32'h8000);
        chk("add_szcv", 32'(rsp_szcv), 32'h9);
        chk("add_flags", 32'(flags_q), 32'h9);

        // SUB from the non-owner leaves flags alone.
        req_valid = 2'b10;
        set_req(1, 4'h1, 16'h0001, 16'h0001, 4'h0, 2'h2);
        tick();
        chk("sub_valid", 32'(rsp_valid), 32'h2);
        chk("sub_szcv", 32'(rsp_szcv), 32'h4);
        chk("sub_flags_kept", 32'(flags_q), 32'h9);

        // Both valid every cycle: alternating grants, one accept per cycle.
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            set_req(0, 4'h2, 16'(k), 16'hFFFF, 4'h0, 2'(k));
            set_req(1, 4'h3, 16'(k * 3), 16'h0100, 4'h0, 2'(3 - k));
            tick();
        end

        // Owner stalls the response: nothing accepted, response held stable.
        rsp_ready = 2'b10;
        set_req(0, 4'h8, 16'h8001, 16'h0, 4'h1, 2'h3);
        tick();
        rsp_ready = 2'b00;
        for (int k = 0; k < 3; k++) tick();
        chk("stall_res", 32'(rsp_res), 32'h0002);
        rsp_ready = 2'b01;
        req_valid = 2'b10;
        tick();

        // Illegal opcode: error flagged, result zero, flags unchanged.
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        set_req(0, 4'h7, 16'h1234, 16'h5678, 4'h0, 2'h2);
        tick();
        chk("illegal_err", 32'(rsp_err), 32'h1);
        chk("illegal_res", 32'(rsp_res), 32'h0);

        // Reset while holding a response.
        rsp_ready = 2'b00;
        set_req(0, 4'h0, 16'hFFFF, 16'h0001, 4'h0, 2'h1);
        tick();
        req_valid = 2'b00;
        tick();
        rst = 1'b1;
        tick();
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_flags", 32'(flags_q), 32'h0);
        rst = 1'b0;
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        set_req(1, 4'h6, 16'hBEEF, 16'h0, 4'h0, 2'h3);
        tick();
        chk("rst_ptr_grant", 32'(rsp_valid), 32'h1);

        // Randomized traffic with occasional reset and back-pressure.
        for (int k = 0; k < 400; k++) begin
            rst       = ($urandom_range(0, 59) == 0);
            req_valid = 2'($urandom_range(0, 3));
            rsp_ready = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            for (int i = 0; i < 2; i++) begin
                set_req(i, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
                        4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
            end
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
